// File: rtl/result_uart_framer.sv
// Buffers 16-bit CPU results in a small word FIFO and frames each word MSB-first into UART bytes.
// Define RESULT_FRAMER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module result_uart_framer #(
  parameter int DATA_LENGTH = 16,
  parameter int NB_BYTE     = 8,
  parameter int FIFO_LOG2   = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [DATA_LENGTH-1:0] i_data,
  input  logic                   i_tx_done,
  output logic                   o_tx_start,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_full,
  output logic                   o_busy,
  output logic [7:0]             o_drop_count
);
  // state   | meaning
  // IDLE    | waiting for a queued word
  // LOAD    | popping FIFO head into the shift register
  // SEND    | o_tx_start pulse for the current byte
  // WAIT    | holding byte until UART reports done
  // SEND_CK | start pulse for checksum byte (macro only)
  // WAIT_CK | waiting on checksum byte done (macro only)
  localparam int DEPTH     = 1 << FIFO_LOG2;
  localparam int CNT_W     = FIFO_LOG2 + 1;
  localparam int NUM_BYTES = DATA_LENGTH / NB_BYTE;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int MSB_LSB   = (NUM_BYTES - 1) * NB_BYTE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] SEND    = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
`ifdef RESULT_FRAMER_CHECKSUM_EN
  localparam logic [2:0] SEND_CK = 3'd4;
  localparam logic [2:0] WAIT_CK = 3'd5;
`endif

  logic [DATA_LENGTH-1:0] r_mem [DEPTH];
  logic [FIFO_LOG2-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [2:0]             r_state;
  logic [DATA_LENGTH-1:0] r_word;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_tx_start, r_full, r_busy;
  logic [NB_BYTE-1:0]     r_tx_data;
  logic [7:0]             r_drop;

  logic                   w_push, w_pop, w_last_done;
  logic [CNT_W-1:0]       w_count_nxt;
  logic [2:0]             w_state_nxt;
  logic [IDX_W-1:0]       w_idx_dec;

  assign w_push      = i_valid && !r_full;
  assign w_pop       = (r_state == LOAD);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_idx_dec   = r_idx - 1'b1;
  assign w_last_done = (r_state == WAIT) && i_tx_done && (r_idx == '0);

`ifdef RESULT_FRAMER_CHECKSUM_EN
  logic [NB_BYTE-1:0] w_cksum;
  always_comb begin
    w_cksum = '0;
    for (int i = 0; i < NUM_BYTES; i++) w_cksum = w_cksum ^ r_word[i*NB_BYTE +: NB_BYTE];
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (r_count != '0) w_state_nxt = LOAD;
      LOAD: w_state_nxt = SEND;
      SEND: w_state_nxt = WAIT;
      WAIT: if (i_tx_done) begin
`ifdef RESULT_FRAMER_CHECKSUM_EN
        w_state_nxt = (r_idx == '0) ? SEND_CK : SEND;
`else
        w_state_nxt = (r_idx == '0) ? IDLE : SEND;
`endif
      end
`ifdef RESULT_FRAMER_CHECKSUM_EN
      SEND_CK: w_state_nxt = WAIT_CK;
      WAIT_CK: if (i_tx_done) w_state_nxt = IDLE;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage array carries no reset; the pointers and count define its contents.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= IDLE;
      r_word     <= '0;
      r_idx      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_full     <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CNT_W'(DEPTH));
      r_busy     <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
      r_tx_start <= (w_state_nxt == SEND)
`ifdef RESULT_FRAMER_CHECKSUM_EN
                    || (w_state_nxt == SEND_CK)
`endif
                    ;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_valid && r_full && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_word    <= r_mem[r_rd_ptr];
        r_idx     <= LAST_IDX;
        r_tx_data <= r_mem[r_rd_ptr][MSB_LSB +: NB_BYTE];
      end else if ((r_state == WAIT) && i_tx_done && (r_idx != '0)) begin
        r_idx     <= w_idx_dec;
        r_tx_data <= r_word[w_idx_dec*NB_BYTE +: NB_BYTE];
      end
`ifdef RESULT_FRAMER_CHECKSUM_EN
      else if (w_last_done) begin
        r_tx_data <= w_cksum;
      end
`endif
    end
  end

  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_full       = r_full;
  assign o_busy       = r_busy;
  assign o_drop_count = r_drop;

`ifndef RESULT_FRAMER_CHECKSUM_EN
  logic w_unused;
  assign w_unused = w_last_done;
`endif
endmodule

// File: tb/tb_result_uart_framer.sv
// Directed bench for result_uart_framer: latency, FIFO order/full/drop, ignored done, reset abort, checksum.
module tb_result_uart_framer;
  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_tx_done;
  logic        o_tx_start, o_full, o_busy;
  logic [7:0]  o_tx_data, o_drop_count;

  logic        auto_done = 1'b0;
  logic        manual_done = 1'b0;
  logic        stall = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  log_q [$];

  assign i_tx_done = auto_done | manual_done;

  result_uart_framer dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_full(o_full), .o_busy(o_busy), .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // UART model: logs each started byte and answers done 10 cycles later unless stalled.
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (!i_reset) begin
      pend = 1'b0;
    end else if (o_tx_start) begin
      if (log_q.size() == 0) first_cyc = cyc;
      log_q.push_back(o_tx_data);
      pend = 1'b1;
      cnt = 0;
    end else if (pend && !stall) begin
      cnt++;
      if (cnt == 10) begin
        auto_done = 1'b1;
        pend = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    i_valid = 1'b1;
    i_data  = d;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    @(negedge clk);
    while (o_busy && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string tag, input logic [7:0] exp [$]);
    chk({tag, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, log_q[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    int c0;
    logic [7:0] e [$];
    #1;
    chk("rst_start", {31'd0, o_tx_start}, 0);
    chk("rst_data", {24'd0, o_tx_data}, 0);
    chk("rst_full", {31'd0, o_full}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_drop", {24'd0, o_drop_count}, 0);
    cycles(3);
    i_reset = 1'b1;
    cycles(2);

    // 1: single word, latency and byte order
    c0 = cyc;
    push_word(16'hA55A);
    wait_idle(100);
    chk("t1_latency", first_cyc - c0, 3);
    e = '{8'hA5, 8'h5A};
    chk_log("t1", e);
    chk("t1_hold", {24'd0, o_tx_data}, 32'h5A);

    // 2: fill FIFO while first frame is stalled
    log_q.delete();
    stall = 1'b1;
    push_word(16'hBEEF);
    cycles(5);
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003); push_word(16'h0004);
    @(negedge clk);
    chk("t2_full", {31'd0, o_full}, 1);
    stall = 1'b0;
    wait_idle(600);
    e = '{8'hBE, 8'hEF, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
    chk_log("t2", e);
    chk("t2_drop", {24'd0, o_drop_count}, 0);
    chk("t2_full_end", {31'd0, o_full}, 0);

    // 3: overflow drops the last two words
    log_q.delete();
    stall = 1'b1;
    push_word(16'hBEEF);
    cycles(5);
    push_word(16'h0011); push_word(16'h0022); push_word(16'h0033);
    push_word(16'h0044); push_word(16'h0055); push_word(16'h0066);
    @(negedge clk);
    chk("t3_drop", {24'd0, o_drop_count}, 2);
    stall = 1'b0;
    wait_idle(600);
    e = '{8'hBE, 8'hEF, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h44};
    chk_log("t3", e);

    // 4: tx_done while IDLE and while in SEND is ignored
    log_q.delete();
    manual_done = 1'b1; cycles(1); manual_done = 1'b0;
    cycles(3);
    chk("t4_idle_busy", {31'd0, o_busy}, 0);
    chk("t4_idle_log", log_q.size(), 0);
    chk("t4_idle_data", {24'd0, o_tx_data}, 32'h44);
    stall = 1'b1;
    push_word(16'hABCD);
    cycles(2);
    chk("t4_in_send", {31'd0, o_tx_start}, 1);
    manual_done = 1'b1; cycles(1); manual_done = 1'b0;
    cycles(5);
    chk("t4_send_log", log_q.size(), 1);
    chk("t4_send_data", {24'd0, o_tx_data}, 32'hAB);
    chk("t4_send_busy", {31'd0, o_busy}, 1);
    stall = 1'b0;
    wait_idle(100);
    e = '{8'hAB, 8'hCD};
    chk_log("t4", e);

    // 5: reset mid-frame with queued words
    stall = 1'b1;
    push_word(16'h1234);
    cycles(5);
    push_word(16'h5555); push_word(16'h6666);
    i_reset = 1'b0;
    #1;
    chk("t5_start", {31'd0, o_tx_start}, 0);
    chk("t5_data", {24'd0, o_tx_data}, 0);
    chk("t5_full", {31'd0, o_full}, 0);
    chk("t5_busy", {31'd0, o_busy}, 0);
    chk("t5_drop", {24'd0, o_drop_count}, 0);
    cycles(2);
    log_q.delete();
    stall = 1'b0;
    i_reset = 1'b1;
    cycles(30);
    chk("t5_nothing_sent", log_q.size(), 0);
    chk("t5_busy_after", {31'd0, o_busy}, 0);

    // 6: frame for 12F0, with checksum when enabled
    log_q.delete();
    push_word(16'h12F0);
    wait_idle(100);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    e = '{8'h12, 8'hF0, 8'hE2};
`else
    e = '{8'h12, 8'hF0};
`endif
    chk_log("t6", e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end
endmodule
